// File: rtl/aes_key_pkg.sv
// AES-128 key schedule constants and the elaboration-time builder for the word1 round-key table.
// Pure constants and functions; no clocked logic.
package aes_key_pkg;

    localparam int AES_KEY_COLS  = 44;
    localparam int WORD1_ROWS    = 4;
    localparam int WORD1_COLS    = 120;
    localparam int WORD1_ENTRIES = WORD1_ROWS * WORD1_COLS;

    typedef logic [WORD1_ENTRIES-1:0][7:0] word1_tbl_t;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    function automatic word1_tbl_t expand_key(input logic [127:0] key);
        logic [AES_KEY_COLS-1:0][31:0] w;
        logic [31:0]                   t;
        logic [8:0]                    idx;
        word1_tbl_t                    tbl;
        w    = '0;
        tbl  = '0;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        for (logic [5:0] i = 6'd4; i < 6'd44; i++) begin
            t = w[i - 6'd1];
            if (i[1:0] == 2'd0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {RCON[i[5:2]], 24'h0};
            end
            w[i] = w[i - 6'd4] ^ t;
        end
        // Row r of column c holds byte r of w[c], counting from the MSB; columns 44..119 stay zero.
        for (logic [2:0] r = 3'd0; r < 3'd4; r++) begin
            for (logic [5:0] c = 6'd0; c < 6'd44; c++) begin
                idx      = 9'(r) * 9'd120 + 9'(c);
                t        = w[c] >> {2'd3 - r[1:0], 3'b000};
                tbl[idx] = t[7:0];
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/add_round_key_word1_rom_if.sv
// Four-port read bundle for the word1 round-key ROM.
// Addresses/enables flow master->slave; registered data returns slave->master.
interface add_round_key_word1_rom_if #(
    parameter int DataWidth    = 8,
    parameter int AddressWidth = 9
);
    logic [AddressWidth-1:0] address0;
    logic [AddressWidth-1:0] address1;
    logic [AddressWidth-1:0] address2;
    logic [AddressWidth-1:0] address3;
    logic                    ce0;
    logic                    ce1;
    logic                    ce2;
    logic                    ce3;
    logic [DataWidth-1:0]    q0;
    logic [DataWidth-1:0]    q1;
    logic [DataWidth-1:0]    q2;
    logic [DataWidth-1:0]    q3;

    modport master (
        output address0, address1, address2, address3,
        output ce0, ce1, ce2, ce3,
        input  q0, q1, q2, q3
    );

    modport slave (
        input  address0, address1, address2, address3,
        input  ce0, ce1, ce2, ce3,
        output q0, q1, q2, q3
    );
endinterface

// File: rtl/rom_read_port.sv
// One registered read port over a constant table; out-of-range addresses read as zero.
// 1-cycle latency; no backpressure, output holds while ce_i is low.
module rom_read_port
    import aes_key_pkg::*;
#(
    parameter int DataWidth    = 8,
    parameter int AddressRange = WORD1_ENTRIES,
    parameter int AddressWidth = 9
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  ce_i,
    input  logic [AddressWidth-1:0]               address_i,
    input  logic [AddressRange-1:0][DataWidth-1:0] table_i,
    output logic [DataWidth-1:0]                  q_o
);

    localparam logic [AddressWidth-1:0] LAST_ADDR = AddressWidth'(AddressRange - 1);

    logic [DataWidth-1:0] q_q = '0;
    logic [DataWidth-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (ce_i) begin
            q_d = (address_i > LAST_ADDR) ? '0 : table_i[address_i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/add_round_key_word1_rom.sv
// Expanded AES-128 round-key ROM (word1[4][120], row-major) with four independent read ports.
// 1-cycle read latency per port; no backpressure, 4 bytes per cycle.
module add_round_key_word1_rom
    import aes_key_pkg::*;
#(
    parameter int           DataWidth    = 8,
    parameter int           AddressRange = 480,
    parameter int           AddressWidth = 9,
    parameter logic [127:0] KEY          = 128'h2b7e151628aed2a6abf7158809cf4f3c
) (
    input  logic                      clk,
    input  logic                      reset,
    add_round_key_word1_rom_if.slave  rd_if
);

    localparam word1_tbl_t ROM = expand_key(KEY);

    logic [3:0]                   port_ce;
    logic [3:0][AddressWidth-1:0] port_addr;
    logic [3:0][DataWidth-1:0]    port_dat;

    assign port_ce   = {rd_if.ce3, rd_if.ce2, rd_if.ce1, rd_if.ce0};
    assign port_addr = {rd_if.address3, rd_if.address2, rd_if.address1, rd_if.address0};

    for (genvar p = 0; p < 4; p++) begin : g_port
        rom_read_port #(
            .DataWidth    (DataWidth),
            .AddressRange (AddressRange),
            .AddressWidth (AddressWidth)
        ) u_port (
            .clk       (clk),
            .reset     (reset),
            .ce_i      (port_ce[p]),
            .address_i (port_addr[p]),
            .table_i   (ROM),
            .q_o       (port_dat[p])
        );
    end

    assign rd_if.q0 = port_dat[0];
    assign rd_if.q1 = port_dat[1];
    assign rd_if.q2 = port_dat[2];
    assign rd_if.q3 = port_dat[3];

endmodule

// File: tb/tb_add_round_key_word1_rom.sv
// Directed checks of the expanded-key ROM against the FIPS-197 AES-128 key schedule example.
module tb_add_round_key_word1_rom;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    add_round_key_word1_rom_if #(.DataWidth(8), .AddressWidth(9)) rd_if ();

    add_round_key_word1_rom dut (
        .clk   (clk),
        .reset (reset),
        .rd_if (rd_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        check({tag, "_q0"}, rd_if.q0, e0);
        check({tag, "_q1"}, rd_if.q1, e1);
        check({tag, "_q2"}, rd_if.q2, e2);
        check({tag, "_q3"}, rd_if.q3, e3);
    endtask

    task automatic step(input logic rst, input logic [3:0] ce,
                        input logic [8:0] a0, input logic [8:0] a1,
                        input logic [8:0] a2, input logic [8:0] a3);
        reset          = rst;
        rd_if.ce0      = ce[0];
        rd_if.ce1      = ce[1];
        rd_if.ce2      = ce[2];
        rd_if.ce3      = ce[3];
        rd_if.address0 = a0;
        rd_if.address1 = a1;
        rd_if.address2 = a2;
        rd_if.address3 = a3;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rd_if.ce0 = 1'b0; rd_if.ce1 = 1'b0; rd_if.ce2 = 1'b0; rd_if.ce3 = 1'b0;
        rd_if.address0 = '0; rd_if.address1 = '0; rd_if.address2 = '0; rd_if.address3 = '0;
        #1;
        check_all("powerup", 8'h00, 8'h00, 8'h00, 8'h00);

        step(1'b1, 4'hf, 9'd4, 9'd124, 9'd244, 9'd364);
        check_all("reset_ce", 8'h00, 8'h00, 8'h00, 8'h00);

        // Back-to-back column reads: w[0], w[4], w[40], w[43]
        step(1'b0, 4'hf, 9'd0, 9'd120, 9'd240, 9'd360);
        check_all("col0", 8'h2b, 8'h7e, 8'h15, 8'h16);
        step(1'b0, 4'hf, 9'd4, 9'd124, 9'd244, 9'd364);
        check_all("col4", 8'ha0, 8'hfa, 8'hfe, 8'h17);
        step(1'b0, 4'hf, 9'd40, 9'd160, 9'd280, 9'd400);
        check_all("col40", 8'hd0, 8'h14, 8'hf9, 8'ha8);
        step(1'b0, 4'hf, 9'd43, 9'd163, 9'd283, 9'd403);
        check_all("col43", 8'hb6, 8'h63, 8'h0c, 8'ha6);

        // Port 0 disabled while its address moves; w[5] = 88542cb1 on the others
        step(1'b0, 4'he, 9'd5, 9'd125, 9'd245, 9'd365);
        check_all("hold0", 8'hb6, 8'h54, 8'h2c, 8'hb1);
        step(1'b0, 4'h0, 9'd0, 9'd0, 9'd0, 9'd0);
        check_all("hold_all", 8'hb6, 8'h54, 8'h2c, 8'hb1);
        step(1'b0, 4'h1, 9'd5, 9'd0, 9'd0, 9'd0);
        check_all("col5_p0", 8'h88, 8'h54, 8'h2c, 8'hb1);

        step(1'b0, 4'hf, 9'd44, 9'd479, 9'd500, 9'd1);
        check_all("zero_oor", 8'h00, 8'h00, 8'h00, 8'h28);
        step(1'b0, 4'hf, 9'd511, 9'd119, 9'd45, 9'd121);
        check_all("edge_cols", 8'h00, 8'h00, 8'h00, 8'hae);

        step(1'b0, 4'hf, 9'd1, 9'd1, 9'd1, 9'd1);
        check_all("same_addr", 8'h28, 8'h28, 8'h28, 8'h28);

        // Reset mid-burst wins over ce, then reads resume immediately
        step(1'b1, 4'hf, 9'd4, 9'd124, 9'd244, 9'd364);
        check_all("reset_mid", 8'h00, 8'h00, 8'h00, 8'h00);
        step(1'b0, 4'hf, 9'd121, 9'd241, 9'd361, 9'd3);
        check_all("resume", 8'hae, 8'hd2, 8'ha6, 8'h09);
        step(1'b0, 4'hf, 9'd7, 9'd127, 9'd247, 9'd367);
        check_all("col7", 8'h2a, 8'h6c, 8'h76, 8'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
